aes_inv_round: RTL and testbench
================================

// Module: aes_inv_round
// PURPOSE
//  Pipelined AES inverse round: the exact decoder for one aes_round step.
//  data_out = InvSubBytes(InvShiftRows(InvMixColumns(data_in ^ round_key))).
//  Sits in the AES decrypt datapath, fed by a round-key schedule; chains with
//  itself. Uses valid/ready handshakes on both sides with full-throughput flow.
// PARAMETERS
//  none (fixed AES-128 state: 128-bit data, 128-bit key)
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    reset, asynchronous, active-high
//  in_valid   in   1    data_in/round_key/last_round valid this cycle
//  in_ready   out  1    stage 1 can accept this cycle
//  data_in    in   128  ciphertext-side state
//  round_key  in   128  round key for this round
//  last_round in   1    1 = skip InvMixColumns (undoes the final encrypt round)
//  out_valid  out  1    data_out valid
//  out_ready  in   1    downstream accepts data_out
//  data_out   out  128  plaintext-side state
// BEHAVIOUR
//  - Byte order: byte i = data[127-8i -: 8]; state column-major (FIPS-197).
//    Column c = bytes 4c..4c+3, row r = byte 4c+r.
//  - Stage 1 (registered): s1 = data_in ^ round_key, then InvMixColumns
//    per column ({0e,0b,0d,09} circulant, GF(2^8) mod 0x11b) unless last_round.
//  - Stage 2 (registered): InvShiftRows (row r rotated right by r),
//    then InvSubBytes (combinational 256-entry inverse S-box, 16 instances).
//  - Latency: 2 cycles from handshake (in_valid & in_ready) to out_valid.
//    Throughput: 1 state per cycle when out_ready is held at 1.
//  - Flow: adv = !out_valid | out_ready; in_ready = !s1_valid | adv.
//    Stage 1 loads on in_valid & in_ready. Stage 2 loads s1 when adv.
//    A bubble collapses: empty stage 2 always takes s1.
//  - Stall: out_valid=1 & out_ready=0 holds data_out stable and holds both
//    stages; a full stage 1 deasserts in_ready that same cycle (combinational).
//  - Simultaneous accept in and out: both stages shift; no loss, no duplicate.
//  - Reset (any time, incl. mid-stream): out_valid=0, s1_valid=0,
//    data_out=128'h0, stage data regs=0. In-flight states are discarded.
//    in_ready=1 while rst is deasserted and the pipe is empty.
//  - in_valid may drop without handshake; data_in is ignored when !in_valid.
// CONFIGURATION
//  AES_INV_ROUND_OUTREG_EN defined: adds a third register stage after
//    InvSubBytes (S-box off the output path). Latency 3 cycles. Same handshake
//    rules, adv propagated back one more stage. Reset clears the extra stage.
//  Not defined: 2-stage pipe as above; data_out driven from stage 2 register
//    through the S-box logic.
// TESTING
//  1 reset: assert rst mid-stream with 2 states in flight -> out_valid=0 and
//    data_out=0 in the same cycle; nothing appears after release.
//  2 data_in=0, key=0, last_round=0, out_ready=1 -> data_out=128'h5252..52
//    (16 bytes of 0x52) exactly 2 cycles later (3 with OUTREG_EN).
//  3 data_in=0, key={16{8'h63}}, last_round=0 -> data_out=128'h0 (uniform
//    column is IMC-invariant, InvSbox(0x63)=0x00).
//  4 data_in={16{8'hed}}, key=0, last_round=1 -> data_out={16{8'h53}}.
//  5 round-trip: 200 random (x,k) through aes_round then aes_inv_round with
//    the same k -> data_out==x for every vector, order preserved.
//  6 backpressure: stream 10 states, toggle out_ready randomly -> all 10
//    emerge in order, data_out stable while out_valid & !out_ready,
//    in_ready=0 exactly when both stages are full and stalled.

Source files
------------

// File: rtl/aes_inv_round.sv
// AES inverse round: data_out = InvSubBytes(InvShiftRows(InvMixColumns(data_in ^ round_key))).
// Latency 2 cycles from input handshake to out_valid (3 with AES_INV_ROUND_OUTREG_EN); 1 state/cycle.
// Backpressure: out_ready=0 holds both stages and data_out; in_ready drops combinationally when stage 1 is full and blocked.
//
// Ports: clk/rst (async active-high), in_valid/in_ready/data_in/round_key/last_round (input side),
//        out_valid/out_ready/data_out (output side). last_round=1 skips InvMixColumns.
// Optional macro AES_INV_ROUND_OUTREG_EN: adds a register after the inverse S-boxes.
// Byte i of a state is bits [127-8i -: 8]; column c holds bytes 4c..4c+3, row r is byte 4c+r.
module aes_inv_round (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] m11(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] m13(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] m14(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [31:0] imc_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3),
                m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3),
                m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3),
                m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3)};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            r[127-32*c -: 32] = imc_col(s[127-32*c -: 32]);
        return r;
    endfunction

    // Row r rotates right by r: new[r][c] = old[r][(c-r) mod 4].
    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    logic         s1_valid, s2_valid;
    logic [127:0] s1_dat, s2_dat;
    logic [127:0] s1_xor;
    logic         adv2;

    assign s1_xor   = data_in ^ round_key;
    assign in_ready = !s1_valid || adv2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_dat   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid)
                s1_dat <= last_round ? s1_xor : inv_mix(s1_xor);
        end
    end

    // Stage 2 keeps the shifted state; an empty stage 2 always takes stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_dat   <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_dat <= inv_shift(s1_dat);
        end
    end

`ifdef AES_INV_ROUND_OUTREG_EN
    logic         s3_valid;
    logic [127:0] s3_dat;
    logic         adv3;

    assign adv3 = !s3_valid || out_ready;
    assign adv2 = !s2_valid || adv3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_dat   <= '0;
        end else if (adv3) begin
            s3_valid <= s2_valid;
            if (s2_valid)
                s3_dat <= inv_sub(s2_dat);
        end
    end

    assign out_valid = s3_valid;
    assign data_out  = s3_dat;
`else
    assign adv2      = !s2_valid || out_ready;
    assign out_valid = s2_valid;
    // The S-box maps 0 to 0x52, so the output is forced to zero while the
    // pipe is empty; this keeps data_out at 0 out of reset.
    assign data_out  = s2_valid ? inv_sub(s2_dat) : 128'h0;
`endif

endmodule

// File: tb/tb_aes_inv_round.sv
module tb_aes_inv_round;

`ifdef AES_INV_ROUND_OUTREG_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] round_key;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    aes_inv_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .round_key  (round_key),
        .last_round (last_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (GF arithmetic, FIPS-197 rules) ----------------
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    // Forward round: MixColumns(ShiftRows(SubBytes(x))) ^ k, no MixColumns when last.
    function automatic logic [127:0] enc_ref(input logic [127:0] x, input logic [127:0] k, input logic lr);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) a[i] = sb[gb(x, i)];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) b[4*c+w] = a[4*((c+w)%4)+w];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = lr ? b[4*c+w] :
                    gmul(8'h02, b[4*c+w]) ^ gmul(8'h03, b[4*c+(w+1)%4]) ^
                    b[4*c+(w+2)%4] ^ b[4*c+(w+3)%4];
        return r ^ k;
    endfunction

    function automatic logic [127:0] inv_ref(input logic [127:0] y, input logic [127:0] k, input logic lr);
        logic [7:0] t [16];
        logic [7:0] m [16];
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) t[i] = gb(y ^ k, i);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                m[4*c+w] = lr ? t[4*c+w] :
                    gmul(8'h0e, t[4*c+w]) ^ gmul(8'h0b, t[4*c+(w+1)%4]) ^
                    gmul(8'h0d, t[4*c+(w+2)%4]) ^ gmul(8'h09, t[4*c+(w+3)%4]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = isb[m[4*((c-w+4)%4)+w]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- cycle stepping and output monitor ----------------
    logic [127:0] exp_q [$];
    logic [127:0] cur_exp;
    int           inflight = 0;
    logic         held = 1'b0;
    logic [127:0] held_dat = '0;
    logic         last_acc, last_emit;

    task automatic monitor();
        logic acc, emit;
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        check("in_ready_vs_occupancy", in_ready, !(inflight == DEPTH && !out_ready));
        if (held) begin
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_data_stable", data_out, held_dat);
        end
        if (emit) begin
            if (exp_q.size() == 0) check("spurious_output", out_valid, 1'b0);
            else check("data_out", data_out, exp_q.pop_front());
        end
        if (acc) exp_q.push_back(cur_exp);
        inflight  = inflight + int'(acc) - int'(emit);
        held      = out_valid && !out_ready;
        held_dat  = data_out;
        last_acc  = acc;
        last_emit = emit;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        in_valid = 1'b0;
        while (inflight != 0 && t < 500) begin
            out_ready = ($urandom_range(3) != 0);
            step();
            t++;
        end
        check("drain_inflight", 128'(inflight), 128'h0);
        check("drain_queue", 128'(exp_q.size()), 128'h0);
    endtask

    // Random round-trip stream: feed enc_ref(x,k) with key k, expect x back.
    task automatic run_stream(input int n, input int vld_pct, input int rdy_pct);
        int sent, guard;
        logic [127:0] x, k;
        logic lr;
        sent = 0;
        guard = 0;
        x = rnd128(); k = rnd128(); lr = ($urandom_range(3) == 0);
        while (sent < n && guard < 20000) begin
            in_valid = ($urandom_range(99) < vld_pct);
            if (in_valid) begin
                data_in    = enc_ref(x, k, lr);
                round_key  = k;
                last_round = lr;
                cur_exp    = x;
            end else begin
                data_in    = rnd128();
                round_key  = rnd128();
                last_round = $urandom_range(1) == 1;
                cur_exp    = '0;
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            step();
            guard++;
            if (last_acc) begin
                sent++;
                x = rnd128(); k = rnd128(); lr = ($urandom_range(3) == 0);
            end
        end
        check("stream_all_sent", 128'(sent), 128'(n));
        drain();
    endtask

    typedef struct {
        logic [127:0] din;
        logic [127:0] key;
        logic         lr;
        logic [127:0] exp;
    } tv_t;

    tv_t tv [7];

    initial begin
        logic [127:0] x, k;
        int lat;
        logic got;

        rst = 1'b1; in_valid = 1'b0; data_in = '0; round_key = '0;
        last_round = 1'b0; out_ready = 1'b0; cur_exp = '0;
        build_sbox();

        #3;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_data_out", data_out, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1'b1);

        // Table of single transactions, each checked for value and latency.
        tv[0] = '{128'h0, 128'h0, 1'b0, {16{8'h52}}};
        tv[1] = '{128'h0, {16{8'h63}}, 1'b0, 128'h0};
        tv[2] = '{{16{8'hed}}, 128'h0, 1'b1, {16{8'h53}}};
        x = rnd128(); k = rnd128();
        tv[3] = '{x, k, 1'b0, inv_ref(x, k, 1'b0)};
        x = rnd128(); k = rnd128();
        tv[4] = '{x, k, 1'b1, inv_ref(x, k, 1'b1)};
        x = rnd128(); k = rnd128();
        tv[5] = '{enc_ref(x, k, 1'b0), k, 1'b0, x};
        x = rnd128(); k = rnd128();
        tv[6] = '{enc_ref(x, k, 1'b1), k, 1'b1, x};

        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; data_in = tv[i].din; round_key = tv[i].key;
            last_round = tv[i].lr; cur_exp = tv[i].exp; out_ready = 1'b1;
            step();
            check("table_accept", last_acc, 1'b1);
            in_valid = 1'b0; data_in = rnd128(); round_key = rnd128();
            lat = 0; got = 1'b0;
            while (!got && lat < 10) begin
                step();
                lat++;
                got = last_emit;
            end
            check("table_got_output", got, 1'b1);
            check("table_latency", 128'(lat), 128'(DEPTH));
        end

        // Round trip, full throughput then mixed flow.
        run_stream(100, 100, 100);
        run_stream(100, 80, 70);

        // Backpressure: 10 states with random out_ready.
        run_stream(10, 100, 40);

        // Reset mid-stream with two states in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; data_in = rnd128(); round_key = rnd128();
            last_round = 1'b0; cur_exp = '0;
            step();
            check("pre_reset_accept", last_acc, 1'b1);
        end
        in_valid = 1'b0;
        check("pre_reset_out_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_data_out", data_out, 128'h0);
        exp_q.delete();
        inflight = 0;
        held = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("post_reset_out_valid", out_valid, 1'b0);
        check("post_reset_in_ready", in_ready, 1'b1);

        // Pipe still works after reset.
        run_stream(20, 90, 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
